micro_sequencer: RTL and testbench

//  Multi-cycle control sequencer downstream of address_mapper. Accepts a 6-bit

---
 rtl/micro_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_micro_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/micro_sequencer.sv
// Multi-cycle control sequencer: walks EXEC/MEM/WB micro-steps per instruction class.
// Optional macro PIPE_DISPATCH_EN: accept the next instruction in the final step of a sequence.
module micro_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       instr_valid,
    input  logic [5:0] mapped_address,
    output logic       instr_ready,
    input  logic       flush,
    input  logic       mem_ack,
    output logic       alu_en,
    output logic [5:0] alu_op,
    output logic       reg_we,
    output logic       mem_re,
    output logic       mem_we,
    output logic       branch_en,
    output logic       jump_en,
    output logic       illegal_instr,
    output logic       mem_timeout,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MEM  = 2'd2,
        S_WB   = 2'd3
    } state_t;

    localparam logic [5:0] OP_NOP        = 6'd0;
    localparam logic [5:0] OP_LOAD       = 6'd11;
    localparam logic [5:0] OP_STORE      = 6'd12;
    localparam logic [5:0] OP_BRANCH     = 6'd13;
    localparam logic [5:0] OP_JAL        = 6'd25;
    localparam logic [5:0] OP_JALR       = 6'd26;
    localparam logic [5:0] OP_LAST_LEGAL = 6'd26;

    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(MEM_TIMEOUT - 1);
    localparam logic [TO_W-1:0] CNT_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

    function automatic logic is_legal(input logic [5:0] code);
        return (code <= OP_LAST_LEGAL);
    endfunction

    function automatic state_t entry_state(input logic [5:0] code);
        if ((code != OP_NOP) && is_legal(code)) begin
            return S_EXEC;
        end else begin
            return S_IDLE;
        end
    endfunction

    state_t          state_q, state_d;
    logic [5:0]      alu_op_q, alu_op_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            alu_en_q, alu_en_d;
    logic            reg_we_q, reg_we_d;
    logic            mem_re_q, mem_re_d;
    logic            mem_we_q, mem_we_d;
    logic            branch_en_q, branch_en_d;
    logic            jump_en_q, jump_en_d;
    logic            illegal_q, illegal_d;
    logic            timeout_q, timeout_d;
    logic            busy_q, busy_d;
    logic            last_step_s;
    logic            ready_s;
    logic            accept_s;

    // Next-state, counter and registered-strobe computation
    always_comb begin
        state_d     = state_q;
        alu_op_d    = alu_op_q;
        cnt_d       = {TO_W{1'b0}};
        illegal_d   = 1'b0;
        timeout_d   = 1'b0;

        case (state_q)
            S_WB:    last_step_s = 1'b1;
            S_EXEC:  last_step_s = (alu_op_q == OP_BRANCH);
            S_MEM:   last_step_s = (alu_op_q == OP_STORE) && mem_ack;
            default: last_step_s = 1'b0;
        endcase

`ifdef PIPE_DISPATCH_EN
        ready_s = (state_q == S_IDLE) || (last_step_s && !flush);
`else
        ready_s = (state_q == S_IDLE);
`endif
        accept_s = instr_valid && ready_s;

        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_EXEC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if ((alu_op_q == OP_LOAD) || (alu_op_q == OP_STORE)) begin
                    state_d = S_MEM;
                end else if (alu_op_q == OP_BRANCH) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                // flush beats both ack and timeout; counter only runs while waiting
                if (flush) begin
                    state_d = S_IDLE;
                end else if (mem_ack) begin
                    state_d = (alu_op_q == OP_LOAD) ? S_WB : S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    state_d = S_MEM;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept_s) begin
            alu_op_d  = mapped_address;
            state_d   = entry_state(mapped_address);
            illegal_d = !is_legal(mapped_address);
            cnt_d     = {TO_W{1'b0}};
        end else begin
            alu_op_d = alu_op_q;
        end

        alu_en_d    = (state_d == S_EXEC);
        branch_en_d = (state_d == S_EXEC) && (alu_op_d == OP_BRANCH);
        jump_en_d   = (state_d == S_EXEC) && ((alu_op_d == OP_JAL) || (alu_op_d == OP_JALR));
        mem_re_d    = (state_d == S_MEM) && (alu_op_d == OP_LOAD);
        mem_we_d    = (state_d == S_MEM) && (alu_op_d == OP_STORE);
        reg_we_d    = (state_d == S_WB);
        busy_d      = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            alu_op_q    <= 6'd0;
            cnt_q       <= {TO_W{1'b0}};
            alu_en_q    <= 1'b0;
            reg_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            branch_en_q <= 1'b0;
            jump_en_q   <= 1'b0;
            illegal_q   <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_op_q    <= alu_op_d;
            cnt_q       <= cnt_d;
            alu_en_q    <= alu_en_d;
            reg_we_q    <= reg_we_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            branch_en_q <= branch_en_d;
            jump_en_q   <= jump_en_d;
            illegal_q   <= illegal_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
        end
    end

    assign instr_ready   = ready_s;
    assign alu_en        = alu_en_q;
    assign alu_op        = alu_op_q;
    assign reg_we        = reg_we_q;
    assign mem_re        = mem_re_q;
    assign mem_we        = mem_we_q;
    assign branch_en     = branch_en_q;
    assign jump_en       = jump_en_q;
    assign illegal_instr = illegal_q;
    assign mem_timeout   = timeout_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: step-list reference model checked every cycle, plus
// directed scenarios with hand-counted strobe expectations and a randomized phase.
module tb_micro_sequencer;

    localparam int MT = 4;
    localparam int ST_EXEC = 1;
    localparam int ST_MEM  = 2;
    localparam int ST_WB   = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic [5:0] mapped_address = 6'd0;
    logic       flush = 1'b0;
    logic       mem_ack = 1'b0;
    logic       instr_ready, alu_en, reg_we, mem_re, mem_we;
    logic       branch_en, jump_en, illegal_instr, mem_timeout, busy;
    logic [5:0] alu_op;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    micro_sequencer #(.MEM_TIMEOUT(MT), .TO_W(5)) dut (
        .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid),
        .mapped_address(mapped_address), .instr_ready(instr_ready),
        .flush(flush), .mem_ack(mem_ack), .alu_en(alu_en), .alu_op(alu_op),
        .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we),
        .branch_en(branch_en), .jump_en(jump_en),
        .illegal_instr(illegal_instr), .mem_timeout(mem_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: list of pending micro-steps ----------------
    int         m_steps[$];
    logic [5:0] m_op = 6'd0;
    int         m_wait = 0;
    bit         m_ill = 1'b0;
    bit         m_to = 1'b0;

    function automatic bit m_ready(input bit fl, input bit ack);
        if (m_steps.size() == 0) return 1'b1;
`ifdef PIPE_DISPATCH_EN
        if (!fl && m_steps.size() == 1 && (m_steps[0] != ST_MEM || ack)) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [15:0] m_outs(input bit fl, input bit ack);
        int f;
        f = (m_steps.size() != 0) ? m_steps[0] : 0;
        return {m_ready(fl, ack), m_steps.size() != 0, f == ST_EXEC,
                f == ST_EXEC && m_op == 6'd13,
                f == ST_EXEC && (m_op == 6'd25 || m_op == 6'd26),
                f == ST_MEM && m_op == 6'd11, f == ST_MEM && m_op == 6'd12,
                f == ST_WB, m_ill, m_to, m_op};
    endfunction

    function automatic logic [15:0] dut_outs();
        return {instr_ready, busy, alu_en, branch_en, jump_en, mem_re, mem_we,
                reg_we, illegal_instr, mem_timeout, alu_op};
    endfunction

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_steps.delete();
            m_op = 6'd0; m_wait = 0; m_ill = 1'b0; m_to = 1'b0;
        end else begin
            bit acc;
            acc = instr_valid && m_ready(flush, mem_ack);
            m_ill = 1'b0;
            m_to = 1'b0;
            if (m_steps.size() != 0) begin
                if (flush) begin
                    m_steps.delete(); m_wait = 0;
                end else if (m_steps[0] == ST_MEM && !mem_ack) begin
                    if (m_wait == MT - 1) begin
                        m_steps.delete(); m_to = 1'b1; m_wait = 0;
                    end else begin
                        m_wait++;
                    end
                end else begin
                    void'(m_steps.pop_front());
                    m_wait = 0;
                end
            end
            if (acc) begin
                m_op = mapped_address;
                m_steps.delete();
                m_wait = 0;
                if (mapped_address > 6'd26) begin
                    m_ill = 1'b1;
                end else if (mapped_address != 6'd0) begin
                    m_steps.push_back(ST_EXEC);
                    if (mapped_address == 6'd11) begin
                        m_steps.push_back(ST_MEM); m_steps.push_back(ST_WB);
                    end else if (mapped_address == 6'd12) begin
                        m_steps.push_back(ST_MEM);
                    end else if (mapped_address != 6'd13) begin
                        m_steps.push_back(ST_WB);
                    end
                end
            end
        end
    end

    // The single per-cycle compare process
    initial forever begin
        @(negedge clk);
        check("cycle_outputs", {16'd0, dut_outs()}, {16'd0, m_outs(flush, mem_ack)});
    end

    // ---------------- directed helpers ----------------
    int c_alu, c_re, c_we, c_reg, c_br, c_jmp, c_ill, c_to, c_busy;

    task automatic issue(input logic [5:0] code);
        bit got;
        int n;
        got = 1'b0; n = 0;
        mapped_address = code;
        instr_valid = 1'b1;
        while (!got && n < 50) begin
            @(negedge clk);
            if (instr_ready) got = 1'b1;
            @(posedge clk); #2;
            n++;
        end
        instr_valid = 1'b0;
        check("issue_accepted", {31'd0, got}, 32'd1);
    endtask

    task automatic run_cycles(input int n, input int ack_at, input int flush_at);
        int memc;
        memc = 0;
        c_alu = 0; c_re = 0; c_we = 0; c_reg = 0; c_br = 0;
        c_jmp = 0; c_ill = 0; c_to = 0; c_busy = 0;
        for (int i = 0; i < n; i++) begin
            if (mem_re || mem_we) memc++;
            mem_ack = (ack_at != 0) && (mem_re || mem_we) && (memc == ack_at);
            flush = (flush_at == i + 1);
            c_alu += int'(alu_en); c_re += int'(mem_re); c_we += int'(mem_we);
            c_reg += int'(reg_we); c_br += int'(branch_en); c_jmp += int'(jump_en);
            c_ill += int'(illegal_instr); c_to += int'(mem_timeout); c_busy += int'(busy);
            @(posedge clk); #2;
        end
        mem_ack = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cyc[5];
        int na;
        int r;
        #7;
        check("reset_outputs", {16'd0, dut_outs()}, 32'h8000);
        @(posedge clk); #2;
        reset_n = 1'b1;
        @(posedge clk); #2;

        // T1: reset in the middle of a load's MEM step
        issue(6'd11);
        @(posedge clk); #2;
        check("t1_in_mem", {31'd0, mem_re}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("t1_reset_drop", {16'd0, dut_outs()}, 32'h8000);
        #4; #4;
        reset_n = 1'b1;
        #1;
        check("t1_ready_after", {31'd0, instr_ready}, 32'd1);
        @(posedge clk); #2;
        issue(6'd1);
        run_cycles(4, 0, 0);
        check("t1_alu", 32'(c_alu), 32'd1);
        check("t1_reg", 32'(c_reg), 32'd1);

        // T2: load, ack on third MEM cycle
        issue(6'd11);
        run_cycles(8, 3, 0);
        check("t2_alu", 32'(c_alu), 32'd1);
        check("t2_mem_re", 32'(c_re), 32'd3);
        check("t2_reg", 32'(c_reg), 32'd1);

        // T3: store with no ack times out
        issue(6'd12);
        run_cycles(8, 0, 0);
        check("t3_mem_we", 32'(c_we), 32'd4);
        check("t3_timeout", 32'(c_to), 32'd1);
        check("t3_reg", 32'(c_reg), 32'd0);

        // T4: illegal and nop codes
        issue(6'd63);
        run_cycles(3, 0, 0);
        check("t4_illegal", 32'(c_ill), 32'd1);
        check("t4_other", 32'(c_alu + c_reg + c_busy), 32'd0);
        issue(6'd0);
        run_cycles(3, 0, 0);
        check("t4_nop", 32'(c_alu + c_reg + c_ill + c_busy), 32'd0);

        // T5: jump flushed in EXEC
        issue(6'd25);
        run_cycles(4, 0, 1);
        check("t5_jump", 32'(c_jmp), 32'd1);
        check("t5_reg", 32'(c_reg), 32'd0);
        check("t5_busy", 32'(c_busy), 32'd1);

        // Branch: single EXEC with branch_en
        issue(6'd13);
        run_cycles(3, 0, 0);
        check("br_branch", 32'(c_br), 32'd1);
        check("br_reg", 32'(c_reg), 32'd0);

        // T6: back-to-back ALU instructions, spacing of accepts
        na = 0;
        mapped_address = 6'd1;
        instr_valid = 1'b1;
        for (int i = 0; i < 60 && na < 5; i++) begin
            @(negedge clk);
            if (instr_ready) begin
                acc_cyc[na] = cyc;
                na++;
            end
            @(posedge clk); #2;
        end
        instr_valid = 1'b0;
        check("t6_accepts", 32'(na), 32'd5);
`ifdef PIPE_DISPATCH_EN
        check("t6_cycles", 32'(acc_cyc[4] - acc_cyc[0]), 32'd8);
`else
        check("t6_cycles", 32'(acc_cyc[4] - acc_cyc[0]), 32'd12);
`endif
        run_cycles(4, 0, 0);

        // Randomized phase: the per-cycle compare does the checking
        for (int i = 0; i < 3000; i++) begin
            instr_valid = ($urandom_range(0, 1) == 0);
            r = $urandom_range(0, 9);
            if (r < 6)       mapped_address = 6'($urandom_range(0, 26));
            else if (r == 6) mapped_address = 6'd11;
            else if (r == 7) mapped_address = 6'd12;
            else if (r == 8) mapped_address = 6'd63;
            else             mapped_address = 6'($urandom_range(27, 62));
            mem_ack = ($urandom_range(0, 2) == 0);
            flush = ($urandom_range(0, 11) == 0);
            reset_n = (i != 1500);
            @(posedge clk); #2;
        end
        reset_n = 1'b1;
        instr_valid = 1'b0;
        flush = 1'b0;
        mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
